// File: rtl/pokemon_soc_keycode_fifo.sv
// Keycode FIFO with an Avalon-MM style register interface.
//   addr 0 : write pushes a keycode, read returns the head (0 when empty)
//   addr 1 : read returns status {count[16:8], overflow[2], full[1], empty[0]},
//            write bit2 clears overflow, write bit0 flushes the FIFO
//   addr 2 : irq mask (only with POKEMON_SOC_KEYCODE_FIFO_IRQ_EN), else reads 0
//   addr 3 : reads 0, writes ignored
// Optional feature macro: POKEMON_SOC_KEYCODE_FIFO_IRQ_EN adds the irq output.
module pokemon_soc_keycode_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  input  logic              out_ready
`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = DEPTH[CW-1:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;

  logic w_wr;
  logic w_push;
  logic w_ctl;
  logic w_flush;
  logic w_clr_ovf;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_do_push;
  logic w_ovf_evt;
  logic w_unused;

  assign w_wr      = chipselect && !write_n;
  assign w_push    = w_wr && (address == 2'd0);
  assign w_ctl     = w_wr && (address == 2'd1);
  assign w_flush   = w_ctl && writedata[0];
  assign w_clr_ovf = w_ctl && writedata[2];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  // out_ready is meaningless while empty, so a pop needs a stored entry
  assign w_pop     = !w_empty && out_ready;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_ovf_evt = w_push && w_full && !w_pop;
  assign w_unused  = ^writedata;

  assign out_valid = !w_empty;
  assign out_port  = w_empty ? '0 : r_mem[r_rd_ptr];

  // storage array is intentionally not reset; entries are hidden while empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
  end

  // pointers and occupancy count; flush wins over a coincident pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // sticky overflow; a new overflow event beats a clear on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ovf <= 1'b0;
    else          r_ovf <= w_ovf_evt || (r_ovf && !w_clr_ovf);
  end

`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
  logic [1:0] r_irq_mask;
  logic       r_irq;

  // irq mask register at address 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      r_irq_mask <= 2'b00;
    else if (w_wr && address == 2'd2) r_irq_mask <= writedata[1:0];
  end

  // registered interrupt, one cycle behind the state that causes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= (r_irq_mask[0] && !w_empty) || (r_irq_mask[1] && r_ovf);
  end

  assign irq = r_irq;
`endif

  // combinational register read, no side effects
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'(out_port);
      2'd1: readdata = {15'd0, 9'(r_count), 5'd0, r_ovf, w_full, w_empty};
`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
      2'd2: readdata = {30'd0, r_irq_mask};
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pokemon_soc_keycode_fifo.sv
// Scoreboard bench for pokemon_soc_keycode_fifo (DATA_W=8, DEPTH=4).
module tb_pokemon_soc_keycode_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = 2'd0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_port;
  logic              out_valid;
  logic              out_ready = 1'b0;
`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
  logic              irq;
`endif

  pokemon_soc_keycode_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready)
`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #10 clk = ~clk;

  // reference model: queue of accepted keycodes plus sticky overflow and mask
  logic [DATA_W-1:0] exp_q[$];
  logic              ovf_m = 1'b0;
  logic [1:0]        mask_m = 2'b00;
  logic              mon_en = 1'b0;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = exp_q.size();
    s = '0;
    s[16:8] = 9'(n);
    s[2] = ovf_m;
    s[1] = (n == DEPTH);
    s[0] = (n == 0);
    return s;
  endfunction

  // monitor: checks the presented head and retires it when consumed
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      if (exp_q.size() == 0) begin
        chk("valid_when_empty", 32'(out_valid), 32'd0);
        chk("port_when_empty", 32'(out_port), 32'd0);
      end else begin
        chk("valid", 32'(out_valid), 32'd1);
        chk("head", 32'(out_port), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // one bus cycle; called at posedge+1, returns at the next posedge+1
  task automatic drive(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [31:0] d, input logic rdy);
    logic exp_irq_next;
    exp_irq_next = (mask_m[0] && exp_q.size() != 0) || (mask_m[1] && ovf_m);
    chipselect = cs; write_n = wn; address = a; writedata = d; out_ready = rdy;
    @(negedge clk); #1;
    if (cs && !wn) begin
      if (a == 2'd0) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d[DATA_W-1:0]);
        else                      ovf_m = 1'b1;
      end else if (a == 2'd1) begin
        if (d[2]) ovf_m = 1'b0;
        if (d[0]) exp_q.delete();
      end
`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
      else if (a == 2'd2) mask_m = d[1:0];
`endif
    end
    @(posedge clk); #1;
`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
    chk("irq", 32'(irq), 32'(exp_irq_next));
`endif
    chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic rdy);
    drive(1'b1, 1'b0, 2'd0, d, rdy);
  endtask

  task automatic check_regs();
    chipselect = 1'b1; write_n = 1'b1; out_ready = 1'b0;
    address = 2'd1; #1 chk("status", readdata, exp_status());
    address = 2'd0; #1 chk("rd_head", readdata, exp_q.size() ? 32'(exp_q[0]) : 32'd0);
    address = 2'd3; #1 chk("rd_addr3", readdata, 32'd0);
    address = 2'd2; #1 chk("rd_addr2", readdata, 32'(mask_m));
    chipselect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int r;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_port", 32'(out_port), 32'd0);
    check_regs();
    mon_en = 1'b1;

    // single push becomes visible next cycle; upper write bits ignored
    push(32'hFFFF_FF1A, 1'b0);
    chk("push_visible", {23'd0, out_valid, out_port}, {23'd0, 1'b1, 8'h1A});
    check_regs();
    drive(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_regs();

    // overflow when pushing five into four entries
    for (int i = 1; i <= 5; i++) push(32'(i), 1'b0);
    check_regs();
    chk("ovf_status", readdata, 32'd0);  // addr2 read with mask 0
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_regs();
    drive(1'b1, 1'b0, 2'd1, 32'h4, 1'b0);
    check_regs();

    // full FIFO: push and pop together keeps count, no overflow
    for (int i = 1; i <= 4; i++) push(32'(i), 1'b0);
    push(32'h77, 1'b1);
    check_regs();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_regs();

    // flush plus overflow clear with three entries, flush beats pop
    for (int i = 0; i < 3; i++) push(32'h40 + 32'(i), 1'b0);
    drive(1'b1, 1'b0, 2'd1, 32'h5, 1'b1);
    check_regs();

    // push into empty with out_ready high is stored, not popped
    push(32'h33, 1'b1);
    check_regs();
    drive(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);

`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
    drive(1'b1, 1'b0, 2'd2, 32'h1, 1'b0);
    push(32'h2C, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    chk("irq_after_valid", 32'(irq), 32'd1);
    drive(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    drive(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    chk("irq_after_drain", 32'(irq), 32'd0);
    check_regs();
`endif

    // asynchronous reset between edges with two entries
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    chipselect = 1'b1; write_n = 1'b1; address = 2'd1;
    #2 reset_n = 1'b0;
    #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_status", readdata, 32'h1);
    exp_q.delete(); ovf_m = 1'b0; mask_m = 2'b00;
`ifdef POKEMON_SOC_KEYCODE_FIFO_IRQ_EN
    chk("async_rst_irq", 32'(irq), 32'd0);
`endif
    #1 reset_n = 1'b1;
    chipselect = 1'b0;
    @(posedge clk); #1;
    check_regs();

    // randomized traffic
    for (int it = 0; it < 800; it++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 55)      push(d, $urandom_range(0, 2) == 0);
      else if (r < 60) begin
        if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
        drive(1'b1, 1'b0, 2'd1, d, $urandom_range(0, 1) == 0);
      end
      else if (r < 65) drive(1'b1, 1'b0, 2'd2, d, $urandom_range(0, 1) == 0);
      else if (r < 70) drive(1'b1, 1'b0, 2'd3, d, $urandom_range(0, 1) == 0);
      else if (r < 80) drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), d, $urandom_range(0, 1) == 0);
      else             drive(1'b0, 1'b0, 2'd0, d, $urandom_range(0, 1) == 0);
      if (it % 8 == 7) check_regs();
    end
    check_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
